// File: rtl/arp_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : arp_pkg
//  Purpose  : Shared ARP field constants, payload lengths and the requester
//             state type used by the ARP blocks.
//  Revision : 1.0  initial release
// ============================================================================
package arp_pkg;

    localparam logic [15:0] ARP_HTYPE_ETH    = 16'h0001;
    localparam logic [15:0] ARP_PTYPE_IPV4   = 16'h0800;
    localparam logic [7:0]  ARP_HLEN_ETH     = 8'h06;
    localparam logic [7:0]  ARP_PLEN_IPV4    = 8'h04;
    localparam logic [15:0] ARP_OPER_REQUEST = 16'h0001;
    localparam logic [15:0] ARP_OPER_REPLY   = 16'h0002;

    localparam int ARP_PAYLOAD_LEN = 28;
    localparam int ETH_MIN_PAYLOAD = 46;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQUEST = 2'd1,
        ST_SEND    = 2'd2,
        ST_WAIT    = 2'd3
    } arp_state_t;

endpackage
`default_nettype wire

// File: rtl/arp_request.sv
`default_nettype none
// ============================================================================
//  Module   : arp_request
//  Purpose  : ARP initiator. Broadcasts an ARP request for a target IPv4
//             address through the tx arbiter, waits for a matching reply and
//             retries on timeout until MAX_ATTEMPTS transmissions are spent.
//  Options  : ARP_REQUEST_PAD_EN - when defined, the payload is zero-padded
//             to the Ethernet minimum (46 bytes); otherwise 28 bytes are sent.
//  Revision : 1.0  initial release
// ============================================================================
module arp_request
    import arp_pkg::*;
#(
    parameter int RETRY_TICKS  = 125_000_000,
    parameter int MAX_ATTEMPTS = 3
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [47:0] local_mac,
    input  logic [31:0] local_ip,
    input  logic        resolve_start,
    input  logic [31:0] resolve_ip,
    output logic        tx_request,
    input  logic        tx_enable,
    output logic        tx_active,
    output logic [7:0]  tx_data,
    output logic [47:0] destination_mac,
    input  logic        reply_valid,
    input  logic [31:0] reply_ip,
    input  logic [47:0] reply_mac,
    output logic        busy,
    output logic        resolved,
    output logic [47:0] resolved_mac,
    output logic        failed
);

    localparam int TIMER_W = (RETRY_TICKS > 1) ? $clog2(RETRY_TICKS) : 1;

`ifdef ARP_REQUEST_PAD_EN
    localparam int FRAME_LEN = ETH_MIN_PAYLOAD;
`else
    localparam int FRAME_LEN = ARP_PAYLOAD_LEN;
`endif

    localparam logic [5:0]         LAST_IDX      = 6'(FRAME_LEN - 1);
    localparam logic [TIMER_W-1:0] TIMER_LOAD    = TIMER_W'(RETRY_TICKS - 1);
    localparam logic [2:0]         ATTEMPT_LIMIT = 3'(MAX_ATTEMPTS);

    arp_state_t         r_state;
    arp_state_t         w_state_nxt;
    logic [31:0]        r_target_ip;
    logic [2:0]         r_attempts;
    logic [5:0]         r_byte_idx;
    logic [TIMER_W-1:0] r_timer;
    logic               r_pending;
    logic [47:0]        r_pending_mac;
    logic               r_resolved;
    logic               r_failed;
    logic [47:0]        r_resolved_mac;

    logic               w_match;
    logic               w_last;
    logic               w_timer_zero;
    logic               w_retry_left;
    logic               w_resolve_now;
    logic [47:0]        w_resolve_mac;
    logic               w_fail_now;
    logic [7:0]         w_byte;

    assign w_match      = reply_valid && (reply_ip == r_target_ip);
    assign w_last       = (r_byte_idx == LAST_IDX);
    assign w_timer_zero = (r_timer == '0);
    assign w_retry_left = (r_attempts < ATTEMPT_LIMIT);

    assign destination_mac = 48'hFFFF_FFFF_FFFF;
    assign resolved        = r_resolved;
    assign failed          = r_failed;
    assign resolved_mac    = r_resolved_mac;

    // State register; asynchronous reset drops busy/tx_request/tx_active at once
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode, status events and state-derived outputs
    always_comb begin
        w_state_nxt   = r_state;
        w_resolve_now = 1'b0;
        w_resolve_mac = w_match ? reply_mac : r_pending_mac;
        w_fail_now    = 1'b0;
        tx_request    = (r_state == ST_REQUEST);
        tx_active     = (r_state == ST_SEND);
        busy          = (r_state != ST_IDLE);
        tx_data       = (r_state == ST_SEND) ? w_byte : 8'h00;
        case (r_state)
            ST_IDLE: begin
                if (resolve_start) begin
                    w_state_nxt = ST_REQUEST;
                end
            end
            ST_REQUEST: begin
                if (w_match) begin
                    w_state_nxt   = ST_IDLE;
                    w_resolve_now = 1'b1;
                end else if (tx_enable) begin
                    w_state_nxt = ST_SEND;
                end
            end
            ST_SEND: begin
                // A reply seen mid-frame only takes effect once the frame is complete
                if (w_last) begin
                    if (r_pending || w_match) begin
                        w_state_nxt   = ST_IDLE;
                        w_resolve_now = 1'b1;
                    end else begin
                        w_state_nxt = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                // A match beats a simultaneous timeout
                if (w_match) begin
                    w_state_nxt   = ST_IDLE;
                    w_resolve_now = 1'b1;
                end else if (w_timer_zero) begin
                    if (w_retry_left) begin
                        w_state_nxt = ST_REQUEST;
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_fail_now  = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ARP request payload byte selected by the byte index (zero past byte 27)
    always_comb begin
        w_byte = 8'h00;
        case (r_byte_idx)
            6'd0:  w_byte = ARP_HTYPE_ETH[15:8];
            6'd1:  w_byte = ARP_HTYPE_ETH[7:0];
            6'd2:  w_byte = ARP_PTYPE_IPV4[15:8];
            6'd3:  w_byte = ARP_PTYPE_IPV4[7:0];
            6'd4:  w_byte = ARP_HLEN_ETH;
            6'd5:  w_byte = ARP_PLEN_IPV4;
            6'd6:  w_byte = ARP_OPER_REQUEST[15:8];
            6'd7:  w_byte = ARP_OPER_REQUEST[7:0];
            6'd8:  w_byte = local_mac[47:40];
            6'd9:  w_byte = local_mac[39:32];
            6'd10: w_byte = local_mac[31:24];
            6'd11: w_byte = local_mac[23:16];
            6'd12: w_byte = local_mac[15:8];
            6'd13: w_byte = local_mac[7:0];
            6'd14: w_byte = local_ip[31:24];
            6'd15: w_byte = local_ip[23:16];
            6'd16: w_byte = local_ip[15:8];
            6'd17: w_byte = local_ip[7:0];
            6'd24: w_byte = r_target_ip[31:24];
            6'd25: w_byte = r_target_ip[23:16];
            6'd26: w_byte = r_target_ip[15:8];
            6'd27: w_byte = r_target_ip[7:0];
            default: w_byte = 8'h00;
        endcase
    end

    // Datapath: target latch, attempt count, byte index, retry timer, results
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_target_ip    <= '0;
            r_attempts     <= '0;
            r_byte_idx     <= '0;
            r_timer        <= '0;
            r_pending      <= 1'b0;
            r_pending_mac  <= '0;
            r_resolved     <= 1'b0;
            r_failed       <= 1'b0;
            r_resolved_mac <= '0;
        end else begin
            if ((r_state == ST_IDLE) && resolve_start) begin
                r_target_ip <= resolve_ip;
                r_resolved  <= 1'b0;
                r_failed    <= 1'b0;
                r_attempts  <= '0;
                r_pending   <= 1'b0;
            end
            if ((r_state == ST_REQUEST) && !w_match && tx_enable) begin
                r_attempts <= r_attempts + 3'd1;
                r_byte_idx <= '0;
                r_pending  <= 1'b0;
            end
            if (r_state == ST_SEND) begin
                r_byte_idx <= r_byte_idx + 6'd1;
                if (w_match) begin
                    r_pending     <= 1'b1;
                    r_pending_mac <= reply_mac;
                end
                if (w_last) begin
                    r_timer <= TIMER_LOAD;
                end
            end
            if (r_state == ST_WAIT) begin
                r_timer <= r_timer - 1'b1;
            end
            if (w_resolve_now) begin
                r_resolved     <= 1'b1;
                r_resolved_mac <= w_resolve_mac;
            end
            if (w_fail_now) begin
                r_failed <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_arp_request.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_arp_request
//  Purpose  : Self-checking bench for arp_request with a behavioural model
//             and directed scenarios.
//  Revision : 1.0  initial release
// ============================================================================
module tb_arp_request;

    localparam int RT  = 100;
    localparam int MAX = 3;
`ifdef ARP_REQUEST_PAD_EN
    localparam int N = 46;
`else
    localparam int N = 28;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [47:0] local_mac = 48'h001C_C0A2_1234;
    logic [31:0] local_ip  = 32'hC0A8_0105;
    logic        resolve_start = 1'b0;
    logic [31:0] resolve_ip = '0;
    logic        tx_request;
    logic        tx_enable = 1'b0;
    logic        tx_active;
    logic [7:0]  tx_data;
    logic [47:0] destination_mac;
    logic        reply_valid = 1'b0;
    logic [31:0] reply_ip = '0;
    logic [47:0] reply_mac = '0;
    logic        busy;
    logic        resolved;
    logic [47:0] resolved_mac;
    logic        failed;

    int total = 0;
    int bad   = 0;
    logic [7:0] cap [0:63];

    arp_request #(.RETRY_TICKS(RT), .MAX_ATTEMPTS(MAX)) dut (
        .clock(clk), .reset_n(reset_n), .local_mac(local_mac), .local_ip(local_ip),
        .resolve_start(resolve_start), .resolve_ip(resolve_ip),
        .tx_request(tx_request), .tx_enable(tx_enable), .tx_active(tx_active),
        .tx_data(tx_data), .destination_mac(destination_mac),
        .reply_valid(reply_valid), .reply_ip(reply_ip), .reply_mac(reply_mac),
        .busy(busy), .resolved(resolved), .resolved_mac(resolved_mac), .failed(failed)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic        m_busy, m_req, m_pend, m_resolved, m_failed;
    int          m_pos, m_wait, m_tries;
    logic [47:0] m_pend_mac, m_mac;
    logic [31:0] m_target;
    logic        m_match;
    assign m_match = reply_valid && (reply_ip == m_target);

    function automatic logic [7:0] exp_byte(input int k);
        logic [367:0] v;
        v = {16'h0001, 16'h0800, 8'h06, 8'h04, 16'h0001, local_mac, local_ip,
             48'h0, m_target, 144'h0};
        return v[367 - 8*k -: 8];
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_busy <= 0; m_req <= 0; m_pos <= -1; m_wait <= 0; m_tries <= 0;
            m_pend <= 0; m_pend_mac <= '0; m_target <= '0;
            m_resolved <= 0; m_failed <= 0; m_mac <= '0;
        end else if (!m_busy) begin
            if (resolve_start) begin
                m_busy <= 1; m_req <= 1; m_target <= resolve_ip;
                m_resolved <= 0; m_failed <= 0; m_tries <= 0;
            end
        end else if (m_req) begin
            if (m_match) begin
                m_busy <= 0; m_req <= 0; m_resolved <= 1; m_mac <= reply_mac;
            end else if (tx_enable) begin
                m_req <= 0; m_pos <= 0; m_tries <= m_tries + 1; m_pend <= 0;
            end
        end else if (m_pos >= 0) begin
            if (m_match) begin
                m_pend <= 1; m_pend_mac <= reply_mac;
            end
            if (m_pos == N - 1) begin
                m_pos <= -1;
                if (m_match || m_pend) begin
                    m_busy <= 0; m_resolved <= 1;
                    m_mac <= m_match ? reply_mac : m_pend_mac;
                end else begin
                    m_wait <= RT;
                end
            end else begin
                m_pos <= m_pos + 1;
            end
        end else begin
            if (m_match) begin
                m_busy <= 0; m_resolved <= 1; m_mac <= reply_mac;
            end else if (m_wait == 1) begin
                if (m_tries < MAX) m_req <= 1;
                else begin m_busy <= 0; m_failed <= 1; end
            end else begin
                m_wait <= m_wait - 1;
            end
        end
    end

    task automatic chk(input string nm, input logic [47:0] act, input logic [47:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Compare process: every cycle out of reset, on the falling edge
    always @(negedge clk) begin
        if (reset_n) begin
            chk("busy", 48'(busy), 48'(m_busy));
            chk("tx_request", 48'(tx_request), 48'(m_req));
            chk("tx_active", 48'(tx_active), 48'(m_pos >= 0));
            chk("tx_data", 48'(tx_data), 48'((m_pos >= 0) ? exp_byte(m_pos) : 8'h00));
            chk("resolved", 48'(resolved), 48'(m_resolved));
            chk("failed", 48'(failed), 48'(m_failed));
            chk("resolved_mac", resolved_mac, m_mac);
            chk("destination_mac", destination_mac, 48'hFFFF_FFFF_FFFF);
        end
    end

    // ---------------- directed helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [31:0] ip);
        resolve_ip = ip; resolve_start = 1'b1;
        tick();
        resolve_start = 1'b0;
    endtask

    task automatic wait_req(input string nm);
        int n = 0;
        while (!tx_request && n < 400) begin tick(); n++; end
        chk(nm, 48'(tx_request), 48'd1);
    endtask

    task automatic send_frame(output int cnt);
        tx_enable = 1'b1;
        tick();
        tx_enable = 1'b0;
        cnt = 0;
        while (tx_active && cnt < 64) begin
            cap[cnt] = tx_data;
            cnt++;
            tick();
        end
    endtask

    task automatic reply(input logic [31:0] ip, input logic [47:0] mac);
        reply_valid = 1'b1; reply_ip = ip; reply_mac = mac;
        tick();
        reply_valid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [367:0] lit;
        int cnt, n, seen;
        lit = {224'h0001_0800_0604_0001_001CC0A21234_C0A80105_000000000000_C0A8010A, 144'h0};

        // Reset values
        tick(); tick();
        chk("rst_busy", 48'(busy), 48'd0);
        chk("rst_tx_request", 48'(tx_request), 48'd0);
        chk("rst_tx_active", 48'(tx_active), 48'd0);
        chk("rst_resolved", 48'(resolved), 48'd0);
        chk("rst_failed", 48'(failed), 48'd0);
        chk("rst_resolved_mac", resolved_mac, 48'd0);
        chk("rst_destination_mac", destination_mac, 48'hFFFF_FFFF_FFFF);
        reset_n = 1'b1;
        tick();

        // 1: basic resolve, grant two cycles after request
        start(32'hC0A8_010A);
        chk("t1_req_after_start", 48'(tx_request), 48'd1);
        chk("t1_busy_after_start", 48'(busy), 48'd1);
        tick(); tick();
        send_frame(cnt);
        chk("t1_frame_len", 48'(cnt), 48'(N));
        for (int k = 0; k < N; k++) chk("t1_byte", 48'(cap[k]), 48'(lit[367 - 8*k -: 8]));
        tick(); tick(); tick();
        reply(32'hC0A8_010A, 48'h1122_3344_5566);
        chk("t1_resolved", 48'(resolved), 48'd1);
        chk("t1_resolved_mac", resolved_mac, 48'h1122_3344_5566);
        chk("t1_busy", 48'(busy), 48'd0);
        tick();

        // 2: no reply, three attempts then failure
        start(32'hC0A8_0114);
        for (int f = 0; f < 3; f++) begin
            wait_req("t2_req");
            send_frame(cnt);
            chk("t2_frame_len", 48'(cnt), 48'(N));
            n = 0;
            while (!tx_request && busy && n < 400) begin tick(); n++; end
            chk("t2_wait_gap", 48'(n), 48'd100);
            if (f < 2) chk("t2_retry_req", 48'(tx_request), 48'd1);
        end
        chk("t2_failed", 48'(failed), 48'd1);
        chk("t2_busy", 48'(busy), 48'd0);
        chk("t2_resolved_mac_held", resolved_mac, 48'h1122_3344_5566);
        seen = 0;
        for (int i = 0; i < 150; i++) begin tick(); if (tx_request) seen++; end
        chk("t2_no_extra_frame", 48'(seen), 48'd0);

        // 3: wrong-IP reply during WAIT is ignored
        start(32'hC0A8_010B);
        chk("t3_failed_cleared", 48'(failed), 48'd0);
        wait_req("t3_req");
        send_frame(cnt);
        for (int i = 0; i < 10; i++) tick();
        reply(32'hC0A8_0163, 48'hAABB_CCDD_EEFF);
        chk("t3_still_busy", 48'(busy), 48'd1);
        chk("t3_not_resolved", 48'(resolved), 48'd0);
        n = 0;
        while (!tx_request && n < 400) begin tick(); n++; end
        chk("t3_retry_gap", 48'(n), 48'd89);
        send_frame(cnt);
        tick();
        reply(32'hC0A8_010B, 48'hAABB_CCDD_EEFF);
        chk("t3_resolved", 48'(resolved), 48'd1);
        chk("t3_mac", resolved_mac, 48'hAABB_CCDD_EEFF);

        // 4: matching reply at byte 10 of SEND
        start(32'hC0A8_0110);
        wait_req("t4_req");
        tx_enable = 1'b1;
        tick();
        tx_enable = 1'b0;
        cnt = 0;
        while (tx_active && cnt < 64) begin
            if (cnt == 10) begin
                reply_valid = 1'b1; reply_ip = 32'hC0A8_0110; reply_mac = 48'h0200_0000_0010;
            end
            cnt++;
            tick();
            reply_valid = 1'b0;
            if (tx_active) chk("t4_no_early_resolve", 48'(resolved), 48'd0);
        end
        chk("t4_frame_len", 48'(cnt), 48'(N));
        chk("t4_resolved", 48'(resolved), 48'd1);
        chk("t4_busy", 48'(busy), 48'd0);
        chk("t4_mac", resolved_mac, 48'h0200_0000_0010);

        // 5: match on the timer==0 cycle wins
        start(32'hC0A8_010E);
        wait_req("t5_req");
        send_frame(cnt);
        for (int i = 0; i < 99; i++) tick();
        reply(32'hC0A8_010E, 48'h0200_0000_000E);
        chk("t5_resolved", 48'(resolved), 48'd1);
        chk("t5_busy", 48'(busy), 48'd0);
        seen = 0;
        for (int i = 0; i < 5; i++) begin if (tx_request) seen++; tick(); end
        chk("t5_no_req", 48'(seen), 48'd0);

        // 6: reset mid-frame, then start-while-busy is ignored
        start(32'hC0A8_010C);
        wait_req("t6_req");
        tx_enable = 1'b1;
        tick();
        tx_enable = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("t6_byte5", 48'(tx_data), 48'h04);
        reset_n = 1'b0;
        #1;
        chk("t6_rst_tx_active", 48'(tx_active), 48'd0);
        chk("t6_rst_tx_request", 48'(tx_request), 48'd0);
        chk("t6_rst_busy", 48'(busy), 48'd0);
        tick();
        reset_n = 1'b1;
        tick();
        start(32'hC0A8_010D);
        start(32'hC0A8_0199);
        wait_req("t6_req2");
        send_frame(cnt);
        chk("t6_target", 48'({cap[24], cap[25], cap[26], cap[27]}), 48'h00_00C0A8010D);
        tick(); tick();
        reply(32'hC0A8_0199, 48'h0300_0000_0099);
        chk("t6_other_ip_ignored", 48'(resolved), 48'd0);
        reply(32'hC0A8_010D, 48'h0A0B_0C0D_0E0F);
        chk("t6_resolved", 48'(resolved), 48'd1);
        chk("t6_mac", resolved_mac, 48'h0A0B_0C0D_0E0F);
        tick(); tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
